dmem_axi_lite_bridge: RTL and testbench

Data-side responder for the MEM stage memory port (ce/we/sel/addr/wdata in, rdata out). It converts each single-word CPU data access into one AXI4-Lite read or write transaction. It stalls the pipeline until the bus completes. It sits between the core's MEM stage and the SoC AXI-Lite interconnect.

---
 rtl/dmem_axi_lite_bridge.sv | 182 ++++++++++++++++++
 tb/tb_dmem_axi_lite_bridge.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_axi_lite_bridge.sv
// MEM-stage data port to AXI4-Lite master bridge; one transaction in flight, stalls until done.
// Optional bus-error capture enabled by defining DMEM_BUS_ERR_REPORT_EN.
module dmem_axi_lite_bridge #(
  parameter logic [31:0] ADDR_MASK = 32'h1FFF_FFFF,
  parameter logic [2:0]  AXI_PROT  = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_write_data_i,
  output logic [31:0] mem_read_data_o,
  input  logic        hold_i,
  output logic        stall_req_o,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic        bus_err_o,
  output logic [31:0] bus_err_addr_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  sel_q;
  logic [31:0] rdata_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic        err_q;
  logic [31:0] err_addr_q;

  logic [31:0] phys_addr;
  logic [31:0] addr_d;
  logic        aw_done_d;
  logic        w_done_d;
  logic        unused_bits;

  assign phys_addr = mem_addr_i & ADDR_MASK;
  assign addr_d    = {phys_addr[31:2], 2'b00};
  assign aw_done_d = aw_done_q | (awvalid_q & m_awready);
  assign w_done_d  = w_done_q | (wvalid_q & m_wready);

  assign unused_bits = ^{phys_addr[1:0], m_rresp, m_bresp};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      rdata_q    <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (mem_ce_i) begin
            addr_q    <= addr_d;
            wdata_q   <= mem_write_data_i;
            sel_q     <= mem_sel_i;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (mem_we_i) begin
              state_q   <= S_WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= S_RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        S_RD_ADDR: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_rvalid) begin
            rready_q <= 1'b0;
            rdata_q  <= m_rdata;
            state_q  <= S_DONE;
`ifdef DMEM_BUS_ERR_REPORT_EN
            if (m_rresp[1]) begin
              err_q      <= 1'b1;
              err_addr_q <= addr_q;
            end
`endif
          end
        end
        S_WR_REQ: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (m_awready) awvalid_q <= 1'b0;
          if (m_wready)  wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_bvalid) begin
            bready_q <= 1'b0;
            state_q  <= S_DONE;
`ifdef DMEM_BUS_ERR_REPORT_EN
            if (m_bresp[1]) begin
              err_q      <= 1'b1;
              err_addr_q <= addr_q;
            end
`endif
          end
        end
        S_DONE: begin
          // Request is still visible here; wait for the pipeline to move on.
          if (!hold_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_req_o = rst &&
    ((state_q == S_IDLE) ? mem_ce_i : (state_q != S_DONE));

  assign mem_read_data_o = rdata_q;
  assign m_araddr  = addr_q;
  assign m_awaddr  = addr_q;
  assign m_arprot  = AXI_PROT;
  assign m_awprot  = AXI_PROT;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;
  assign m_awvalid = awvalid_q;
  assign m_wvalid  = wvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = sel_q;
  assign m_bready  = bready_q;
  assign bus_err_o      = err_q;
  assign bus_err_addr_o = err_addr_q;

endmodule

// File: tb/tb_dmem_axi_lite_bridge.sv
// Directed bench for dmem_axi_lite_bridge with a delay-programmable AXI-Lite slave.
// Bus-error expectations follow DMEM_BUS_ERR_REPORT_EN.
module tb_dmem_axi_lite_bridge;

`ifdef DMEM_BUS_ERR_REPORT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        mem_ce_i = 0, mem_we_i = 0, hold_i = 0;
  logic [3:0]  mem_sel_i = 0;
  logic [31:0] mem_addr_i = 0, mem_write_data_i = 0;
  logic [31:0] mem_read_data_o;
  logic        stall_req_o;
  logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
  logic [2:0]  m_arprot, m_awprot;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic        m_bvalid, m_bready;
  logic [1:0]  m_rresp, m_bresp;
  logic [3:0]  m_wstrb;
  logic        bus_err_o;
  logic [31:0] bus_err_addr_o;

  dmem_axi_lite_bridge dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i),
    .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_write_data_i(mem_write_data_i),
    .mem_read_data_o(mem_read_data_o),
    .hold_i(hold_i), .stall_req_o(stall_req_o),
    .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready),
    .bus_err_o(bus_err_o), .bus_err_addr_o(bus_err_addr_o)
  );

  // Slave configuration
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] s_rdata = 0;
  logic [1:0]  s_resp = 0;

  int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
  logic r_pend, b_pend, aw_got, w_got;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  int n_ar = 0, n_aw = 0, overlap = 0, err_cycles = 0;

  wire aw_hs = m_awvalid && m_awready;
  wire w_hs  = m_wvalid && m_wready;
  wire aw_ok = aw_got || aw_hs;
  wire w_ok  = w_got || w_hs;

  assign m_arready = m_arvalid && (ar_cnt >= ar_dly);
  assign m_awready = m_awvalid && (aw_cnt >= aw_dly);
  assign m_wready  = m_wvalid && (w_cnt >= w_dly);
  assign m_rvalid  = r_pend && (r_cnt >= r_dly);
  assign m_bvalid  = b_pend && (b_cnt >= b_dly);
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_resp;
  assign m_bresp   = s_resp;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
      r_cnt <= 0; b_cnt <= 0;
      r_pend <= 0; b_pend <= 0;
      aw_got <= 0; w_got <= 0;
    end else begin
      ar_cnt <= (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
      aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_wvalid && !m_wready) ? w_cnt + 1 : 0;
      if (m_arvalid && m_arready) begin
        r_pend <= 1; r_cnt <= 0;
        cap_araddr <= m_araddr; n_ar <= n_ar + 1;
      end else if (m_rvalid && m_rready) r_pend <= 0;
      else if (r_pend) r_cnt <= r_cnt + 1;
      if (aw_hs) begin
        cap_awaddr <= m_awaddr; n_aw <= n_aw + 1;
      end
      if (w_hs) begin
        cap_wdata <= m_wdata; cap_wstrb <= m_wstrb;
      end
      if (m_bvalid && m_bready) b_pend <= 0;
      else if (b_pend) b_cnt <= b_cnt + 1;
      if (aw_ok && w_ok) begin
        aw_got <= 0; w_got <= 0; b_pend <= 1; b_cnt <= 0;
      end else begin
        aw_got <= aw_ok; w_got <= w_ok;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (m_arvalid && m_awvalid) overlap <= overlap + 1;
      if (bus_err_o) err_cycles <= err_cycles + 1;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int   r_cyc, r_arv, r_awv, r_wv, r_br;
  logic r_err;

  // Present one access and run until the stall drops (left in DONE).
  task automatic run_access(input logic we, input logic [3:0] sel,
                            input logic [31:0] addr,
                            input logic [31:0] wd);
    bit done = 0;
    @(negedge clk);
    mem_ce_i = 1; mem_we_i = we; mem_sel_i = sel;
    mem_addr_i = addr; mem_write_data_i = wd;
    r_cyc = 0; r_arv = 0; r_awv = 0; r_wv = 0; r_br = 0; r_err = 0;
    while (!done && r_cyc < 100) begin
      #1;
      if (m_arvalid) r_arv++;
      if (m_awvalid) r_awv++;
      if (m_wvalid)  r_wv++;
      if (m_bready)  r_br++;
      if (!stall_req_o) begin
        done = 1; r_err = bus_err_o;
      end else begin
        r_cyc++;
        @(negedge clk);
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout: stall still %b after %0d cycles, need 0",
               stall_req_o, r_cyc);
    end
    mem_ce_i = 0; mem_we_i = 0;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    int ard, rd, awd, wd, bd;
    logic [31:0] exp_addr;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[6];
  logic [31:0] last_rd;
  int n0, e0;

  initial begin
    vecs[0] = '{1'b0, 4'hF, 32'h8000_1004, 32'hDEAD_BEEF,
                0, 0, 0, 0, 0, 32'h0000_1004, 3};
    vecs[1] = '{1'b1, 4'b0100, 32'hA000_0011, 32'h5A5A_5A5A,
                0, 0, 3, 0, 0, 32'h0000_0010, 6};
    vecs[2] = '{1'b1, 4'hF, 32'h0000_0200, 32'h1234_5678,
                0, 0, 0, 0, 5, 32'h0000_0200, 8};
    vecs[3] = '{1'b0, 4'hF, 32'hBFC0_0007, 32'h0BAD_F00D,
                2, 3, 0, 0, 0, 32'h1FC0_0004, 8};
    vecs[4] = '{1'b1, 4'b0000, 32'hFFFF_FFFC, 32'hCAFE_BABE,
                0, 0, 0, 2, 1, 32'h1FFF_FFFC, 6};
    vecs[5] = '{1'b0, 4'hF, 32'h0000_0000, 32'hFFFF_FFFF,
                0, 1, 0, 0, 0, 32'h0000_0000, 4};

    #2;
    chk("rst_stall", 32'(stall_req_o), 0);
    chk("rst_arvalid", 32'(m_arvalid), 0);
    chk("rst_awvalid", 32'(m_awvalid), 0);
    chk("rst_wvalid", 32'(m_wvalid), 0);
    chk("rst_rready", 32'(m_rready), 0);
    chk("rst_bready", 32'(m_bready), 0);
    chk("rst_rdata", mem_read_data_o, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_awaddr", m_awaddr, 0);
    chk("rst_wdata", m_wdata, 0);
    chk("rst_wstrb", 32'(m_wstrb), 0);
    chk("rst_bus_err", 32'(bus_err_o), 0);
    @(negedge clk); rst = 1;
    chk("arprot", 32'(m_arprot), 0);
    chk("awprot", 32'(m_awprot), 0);
    last_rd = 0;

    foreach (vecs[i]) begin
      ar_dly = vecs[i].ard; r_dly = vecs[i].rd;
      aw_dly = vecs[i].awd; w_dly = vecs[i].wd;
      b_dly = vecs[i].bd; s_rdata = vecs[i].data;
      s_resp = 2'b00;
      n0 = n_ar + n_aw;
      run_access(vecs[i].we, vecs[i].sel, vecs[i].addr, vecs[i].data);
      chk($sformatf("v%0d_latency", i), 32'(r_cyc), 32'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_txn_count", i), 32'(n_ar + n_aw - n0), 1);
      chk($sformatf("v%0d_arvalid_cycles", i), 32'(r_arv),
          vecs[i].we ? 0 : 32'(vecs[i].ard + 1));
      chk($sformatf("v%0d_awvalid_cycles", i), 32'(r_awv),
          vecs[i].we ? 32'(vecs[i].awd + 1) : 0);
      if (vecs[i].we) begin
        chk($sformatf("v%0d_awaddr", i), cap_awaddr, vecs[i].exp_addr);
        chk($sformatf("v%0d_wdata", i), cap_wdata, vecs[i].data);
        chk($sformatf("v%0d_wstrb", i), 32'(cap_wstrb), 32'(vecs[i].sel));
        chk($sformatf("v%0d_wvalid_cycles", i), 32'(r_wv),
            32'(vecs[i].wd + 1));
        chk($sformatf("v%0d_bready_cycles", i), 32'(r_br),
            32'(vecs[i].bd + 1));
        chk($sformatf("v%0d_rdata_kept", i), mem_read_data_o, last_rd);
      end else begin
        chk($sformatf("v%0d_araddr", i), cap_araddr, vecs[i].exp_addr);
        chk($sformatf("v%0d_rdata", i), mem_read_data_o, vecs[i].data);
        last_rd = vecs[i].data;
      end
    end

    // hold_i keeps DONE with the request still present
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
    s_rdata = 32'h1357_9BDF;
    n0 = n_ar;
    run_access(1'b0, 4'hF, 32'h0000_0040, 0);
    mem_ce_i = 1; hold_i = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk($sformatf("hold%0d_stall", k), 32'(stall_req_o), 0);
      chk($sformatf("hold%0d_arvalid", k), 32'(m_arvalid), 0);
      chk($sformatf("hold%0d_rdata", k), mem_read_data_o, 32'h1357_9BDF);
    end
    hold_i = 0; mem_ce_i = 0;
    repeat (2) @(negedge clk);
    chk("hold_txn_count", 32'(n_ar - n0), 1);

    // Reset while waiting in RD_DATA
    r_dly = 20;
    @(negedge clk);
    mem_ce_i = 1; mem_addr_i = 32'h0000_0080;
    for (int k = 0; k < 10 && !m_rready; k++) @(negedge clk);
    chk("rst_mid_reached_rdata", 32'(m_rready), 1);
    rst = 0; #1;
    chk("rst_mid_arvalid", 32'(m_arvalid), 0);
    chk("rst_mid_rready", 32'(m_rready), 0);
    chk("rst_mid_stall", 32'(stall_req_o), 0);
    chk("rst_mid_rdata", mem_read_data_o, 0);
    mem_ce_i = 0;
    @(negedge clk); rst = 1; r_dly = 0;
    s_rdata = 32'h2468_ACE0;
    run_access(1'b0, 4'hF, 32'h0000_0084, 0);
    chk("post_rst_latency", 32'(r_cyc), 3);
    chk("post_rst_rdata", mem_read_data_o, 32'h2468_ACE0);
    chk("post_rst_araddr", cap_araddr, 32'h0000_0084);

    // Error responses
    s_resp = 2'b10;
    e0 = err_cycles;
    run_access(1'b1, 4'hF, 32'h0000_2000, 32'h0000_0001);
    chk("berr_pulse_at_done", 32'(r_err), 32'(ERR_EN));
    repeat (3) @(negedge clk);
    chk("berr_pulse_len", 32'(err_cycles - e0), 32'(ERR_EN));
    chk("berr_addr", bus_err_addr_o, ERR_EN ? 32'h0000_2000 : 0);
    s_resp = 2'b11; s_rdata = 32'h7777_0001;
    e0 = err_cycles;
    run_access(1'b0, 4'hF, 32'h8000_3009, 0);
    chk("rerr_rdata", mem_read_data_o, 32'h7777_0001);
    repeat (3) @(negedge clk);
    chk("rerr_pulse_len", 32'(err_cycles - e0), 32'(ERR_EN));
    chk("rerr_addr", bus_err_addr_o, ERR_EN ? 32'h0000_3008 : 0);
    s_resp = 2'b00;

    chk("ar_aw_overlap", 32'(overlap), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
